// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the RV32I pipeline front end. Used by the fetch
// stage, the IF/ID register, the ID/EX register and the hazard unit.
//   XLEN       : datapath / address width
//   NOP_INSTR  : addi x0,x0,0, written into pipeline registers as a bubble
//   if_state_t : fetch FSM states
//   if_id_t    : contents of the IF/ID pipeline register
//   align_pc   : forces a target address onto a word boundary
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } if_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Instructions are 32-bit aligned, so the low two bits of any target
    // address are simply cleared.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). Only one request is ever outstanding.
//   imem_req    : master -> slave, fetch request
//   imem_addr   : master -> slave, fetch address
//   imem_gnt    : slave -> master, request accepted this cycle
//   imem_rvalid : slave -> master, response data valid
//   imem_rdata  : slave -> master, returned instruction
// ---------------------------------------------------------------------------
interface if_stage_if;
    import rv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_stage_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with hold and flush controls.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   i_stall  : keep every field unchanged
//   i_flush  : replace contents with a bubble (wins over i_stall)
//   i_load   : a fetched instruction is available on i_data
//   i_data   : instruction to load (valid forced to 1 on load)
//   o_data   : current register contents
// A bubble keeps the pc field, clears valid and writes NOP_INSTR, so a
// cycle with neither stall nor a delivered instruction also becomes a bubble.
// ---------------------------------------------------------------------------
module if_id_reg
    import rv_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_stall,
    input  logic   i_flush,
    input  logic   i_load,
    input  if_id_t i_data,
    output if_id_t o_data
);

    if_id_t r_data;

    // Priority: reset, then flush, then hold, then load-or-bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data.pc    <= '0;
            r_data.instr <= NOP;
            r_data.valid <= 1'b0;
        end else if (i_flush) begin
            r_data.instr <= NOP;
            r_data.valid <= 1'b0;
        end else if (!i_stall) begin
            if (i_load) begin
                r_data.pc    <= i_data.pc;
                r_data.instr <= i_data.instr;
                r_data.valid <= 1'b1;
            end else begin
                r_data.instr <= NOP;
                r_data.valid <= 1'b0;
            end
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, issues
// single-outstanding requests to instruction memory, parks one returned
// instruction while the pipeline is stalled and writes the IF/ID register.
//   clk             : clock, rising edge
//   rst             : synchronous active-high reset (memory shares it)
//   pc_write_enable : from hazard unit, 0 = hold PC
//   if_id_write     : from hazard unit, 0 = hold IF/ID
//   redirect_valid  : taken branch/jump from EX
//   redirect_pc     : redirect target, low two bits ignored
//   imem            : instruction-memory bus (if_stage_if.master)
//   if_id_pc        : PC of instruction in IF/ID
//   if_id_instr     : instruction in IF/ID
//   if_id_valid     : IF/ID holds a real instruction
// Optional build macro IF_STAGE_PERF_EN adds:
//   perf_fetch_cnt  : cycles in which IF/ID was loaded with a valid instruction
//   perf_stall_cnt  : cycles stalled without a redirect
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int                XLEN      = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write_enable,
    input  logic             if_id_write,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    if_stage_if.master       imem,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);
    import rv_pkg::*;

    if_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_req;
    logic            r_drop;
    logic [XLEN-1:0] r_bufPc;
    logic [31:0]     r_bufInstr;

    logic            w_stall;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pcNext;
    logic            w_rspLive;
    logic            w_load;
    if_id_t          w_loadData;
    if_id_t          w_ifId;

    assign w_stall    = !pc_write_enable || !if_id_write;
    // Redirects are ignored in the single post-reset IDLE cycle.
    assign w_redirect = redirect_valid && (r_state != IDLE);
    assign w_target   = align_pc(redirect_pc);
    assign w_pcNext   = r_pc + XLEN'(4);
    // A response is live only if it was not issued before a redirect.
    assign w_rspLive  = (r_state == WAIT) && imem.imem_rvalid && !r_drop;
    assign w_load     = !w_redirect && !w_stall && (w_rspLive || (r_state == HOLD));

    // Source of the instruction loaded into IF/ID: the parked copy when
    // leaving HOLD, otherwise the memory response arriving right now.
    always_comb begin
        w_loadData       = '0;
        w_loadData.valid = 1'b1;
        if (r_state == HOLD) begin
            w_loadData.pc    = r_bufPc;
            w_loadData.instr = r_bufInstr;
        end else begin
            w_loadData.pc    = r_pc;
            w_loadData.instr = imem.imem_rdata;
        end
    end

    // Fetch FSM. r_drop marks the outstanding response as stale after a
    // redirect, so it is swallowed when it finally arrives. The PC only
    // advances when its instruction actually reaches IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_drop     <= 1'b0;
            r_bufPc    <= '0;
            r_bufInstr <= '0;
        end else begin
            if (w_redirect) begin
                r_pc       <= w_target;
                r_bufPc    <= '0;
                r_bufInstr <= '0;
            end
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_gnt) begin
                        r_state <= WAIT;
                        r_req   <= 1'b0;
                        r_drop  <= w_redirect;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (w_redirect || r_drop || !w_stall) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            if (!w_redirect && !r_drop) begin
                                r_pc <= w_pcNext;
                            end
                        end else begin
                            r_state    <= HOLD;
                            r_bufPc    <= r_pc;
                            r_bufInstr <= imem.imem_rdata;
                        end
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redirect || !w_stall) begin
                        r_state    <= REQ;
                        r_req      <= 1'b1;
                        r_bufPc    <= '0;
                        r_bufInstr <= '0;
                        if (!w_redirect) begin
                            r_pc <= w_pcNext;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall),
        .i_flush (w_redirect),
        .i_load  (w_load),
        .i_data  (w_loadData),
        .o_data  (w_ifId)
    );

    assign if_id_pc    = w_ifId.pc;
    assign if_id_instr = w_ifId.instr;
    assign if_id_valid = w_ifId.valid;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_fetchCnt;
    logic [31:0] r_stallCnt;

    // Stall cycles are counted on the raw redirect input so a flush cycle
    // never counts as a stall, even in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchCnt <= '0;
            r_stallCnt <= '0;
        end else begin
            if (w_load) begin
                r_fetchCnt <= r_fetchCnt + 32'd1;
            end
            if (w_stall && !redirect_valid) begin
                r_stallCnt <= r_stallCnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetchCnt;
    assign perf_stall_cnt = r_stallCnt;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A transaction-level reference model
// (pending-request flag, stale flag, parked instruction) predicts the bus
// request and the IF/ID contents every cycle. Directed sequences cover the
// zero-wait stream, stall parking, redirects and reset; a randomized phase
// follows. Honour IF_STAGE_PERF_EN to also check the counters.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write_enable;
    logic        if_id_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    if_stage_if bus ();

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc_write_enable (pc_write_enable),
        .if_id_write     (if_id_write),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (bus),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid)
`ifdef IF_STAGE_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int totalChecks = 0;
    int badChecks   = 0;

    // Memory-side bookkeeping (stimulus only).
    bit          memPending;
    logic [31:0] memAddr;

    // Reference model state.
    bit          mStartup;
    logic [31:0] mPc;
    bit          mOut;
    bit          mStale;
    bit          mParked;
    logic [31:0] mParkPc;
    logic [31:0] mParkInstr;
    logic [31:0] mIdPc;
    logic [31:0] mIdInstr;
    bit          mIdValid;
    logic [31:0] mFetchCnt;
    logic [31:0] mStallCnt;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h8) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic modelReset();
        mStartup   = 1'b1;
        mPc        = 32'h0;
        mOut       = 1'b0;
        mStale     = 1'b0;
        mParked    = 1'b0;
        mParkPc    = 32'h0;
        mParkInstr = 32'h0;
        mIdPc      = 32'h0;
        mIdInstr   = NOP;
        mIdValid   = 1'b0;
        mFetchCnt  = 32'h0;
        mStallCnt  = 32'h0;
    endtask

    // Holds rst for one edge, checks the reset values, then releases it.
    task automatic doReset();
        rst             = 1'b1;
        pc_write_enable = 1'b1;
        if_id_write     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        memPending      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(bus.imem_req), 32'h0);
        checkOutput("rst_if_id_pc", if_id_pc, 32'h0);
        checkOutput("rst_if_id_instr", if_id_instr, NOP);
        checkOutput("rst_if_id_valid", 32'(if_id_valid), 32'h0);
`ifdef IF_STAGE_PERF_EN
        checkOutput("rst_perf_fetch", perf_fetch_cnt, 32'h0);
        checkOutput("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
        rst = 1'b0;
        modelReset();
    endtask

    // One clock cycle: compare outputs against the model, drive inputs,
    // advance memory and model, then return on the following negedge.
    task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] rpc,
                                 input bit gntOk, input bit rvOk);
        bit          mReq;
        bit          gnt;
        bit          rv;
        bit          redirEff;
        bit          oldParked;
        bit          deliver;
        logic [31:0] rdata;
        logic [31:0] dPc;
        logic [31:0] dInstr;

        mReq = !mStartup && !mOut && !mParked;
        checkOutput("imem_req", 32'(bus.imem_req), 32'(mReq));
        if (mReq) checkOutput("imem_addr", bus.imem_addr, mPc);
        checkOutput("if_id_pc", if_id_pc, mIdPc);
        checkOutput("if_id_instr", if_id_instr, mIdInstr);
        checkOutput("if_id_valid", 32'(if_id_valid), 32'(mIdValid));

        gnt   = gntOk && mReq;
        rv    = rvOk && memPending;
        rdata = rv ? memData(memAddr) : $urandom;

        pc_write_enable = !stall;
        if_id_write     = !stall;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        bus.imem_gnt    = gnt;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdata;

        if (rv)  memPending = 1'b0;
        if (gnt) begin
            memPending = 1'b1;
            memAddr    = mPc;
        end

        redirEff  = redir && !mStartup;
        deliver   = 1'b0;
        oldParked = mParked;
        dPc       = 32'h0;
        dInstr    = 32'h0;
        if (mStartup) begin
            mStartup = 1'b0;
            if (!stall) begin
                mIdInstr = NOP;
                mIdValid = 1'b0;
            end
        end else begin
            if (rv) begin
                mOut = 1'b0;
                if (!mStale && !redirEff) begin
                    if (stall) begin
                        mParked    = 1'b1;
                        mParkPc    = mPc;
                        mParkInstr = rdata;
                    end else begin
                        deliver = 1'b1;
                        dPc     = mPc;
                        dInstr  = rdata;
                    end
                end
                mStale = 1'b0;
            end else if (mOut && redirEff) begin
                mStale = 1'b1;
            end
            if (gnt) begin
                mOut   = 1'b1;
                mStale = redirEff;
            end
            if (oldParked && !stall && !redirEff) begin
                deliver = 1'b1;
                dPc     = mParkPc;
                dInstr  = mParkInstr;
                mParked = 1'b0;
            end
            if (redirEff) begin
                mPc      = rpc & ~32'h3;
                mParked  = 1'b0;
                mIdInstr = NOP;
                mIdValid = 1'b0;
            end else if (deliver) begin
                mIdPc     = dPc;
                mIdInstr  = dInstr;
                mIdValid  = 1'b1;
                mPc       = mPc + 32'h4;
                mFetchCnt = mFetchCnt + 32'h1;
            end else if (!stall) begin
                mIdInstr = NOP;
                mIdValid = 1'b0;
            end
        end
        if (stall && !redir) mStallCnt = mStallCnt + 32'h1;

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        doReset();

        // Zero-wait memory: address 0 and 4 stream into IF/ID.
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("zw_addr", bus.imem_addr, 32'(i * 4));
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput("zw_if_id_pc", if_id_pc, 32'(i * 4));
            checkOutput("zw_if_id_valid", 32'(if_id_valid), 32'h1);
        end

        // Stall while the response for pc 0x8 arrives: it is parked.
        checkOutput("zw_addr8", bus.imem_addr, 32'h8);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("hold_if_id_pc", if_id_pc, 32'h4);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("hold_if_id_pc2", if_id_pc, 32'h4);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rel_if_id_pc", if_id_pc, 32'h8);
        checkOutput("rel_if_id_instr", if_id_instr, 32'h0050_0093);
        checkOutput("rel_if_id_valid", 32'(if_id_valid), 32'h1);
        checkOutput("rel_addr", bus.imem_addr, 32'hC);

        // Redirect during WAIT, stale response two cycles later.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 32'h100, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("redir_bubble_instr", if_id_instr, NOP);
        checkOutput("redir_bubble_valid", 32'(if_id_valid), 32'h0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("redir_drop_valid", 32'(if_id_valid), 32'h0);
        checkOutput("redir_req", 32'(bus.imem_req), 32'h1);
        checkOutput("redir_addr", bus.imem_addr, 32'h100);

        // Redirect and stall together: the flush still happens.
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pre_flush_valid", 32'(if_id_valid), 32'h1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 32'h203, 0, 0);
        checkOutput("flush_stall_instr", if_id_instr, NOP);
        checkOutput("flush_stall_valid", 32'(if_id_valid), 32'h0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("flush_stall_addr", bus.imem_addr, 32'h200);

        // Reset while a response is outstanding.
        applyStimulus(0, 0, 0, 1, 0);
        doReset();
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("post_rst_req", 32'(bus.imem_req), 32'h1);
        checkOutput("post_rst_addr", bus.imem_addr, 32'h0);

`ifdef IF_STAGE_PERF_EN
        // Three stall cycles, then ten zero-wait fetches.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 1);
        end
        checkOutput("perf_fetch_10", perf_fetch_cnt, 32'd10);
        checkOutput("perf_stall_3", perf_stall_cnt, 32'd3);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                              $urandom, $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1);
            end
        end

`ifdef IF_STAGE_PERF_EN
        checkOutput("perf_fetch_rand", perf_fetch_cnt, mFetchCnt);
        checkOutput("perf_stall_rand", perf_stall_cnt, mStallCnt);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the hazard-detection unit.
- Owns the PC, issues single-outstanding requests to instruction memory, and writes the IF/ID pipeline register consumed by decode and hazard detection.
- Honours the stall outputs of the hazard unit (pc_write_enable, IF/ID write) and branch/jump redirects from EX.
- Buffers one instruction returned during a stall so no fetch is lost.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding written to IF/ID on bubble/flush (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_write_enable  in  1  from hazard unit; 0 = hold PC.
- if_id_write  in  1  from hazard unit; 0 = hold IF/ID. Driven identically to pc_write_enable; stall = !pc_write_enable | !if_id_write.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  XLEN  target PC; bits[1:0] ignored (forced 0).
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (= pc while imem_req=1).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after gnt.
- imem_rdata  in  32  returned instruction.
- if_id_pc  out  XLEN  PC of instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset state: pc=RESET_PC, state=IDLE, imem_req=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, hold buffer empty, drop=0. rst dominates every other input.
- Reset mid-operation: imem shares rst, so no stale response survives reset and none is filtered.
- States:
  - IDLE: one cycle after reset, then -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt -> WAIT.
  - WAIT: imem_req=0; waits for imem_rvalid.
  - HOLD: instruction parked in hold buffer; waits for stall release.
- WAIT, rvalid=1, drop=1: discard data, clear drop, -> REQ.
- WAIT, rvalid=1, drop=0, no stall: IF/ID <= {pc, rdata, 1}; pc <= pc+4 (mod 2^XLEN); -> REQ.
- WAIT, rvalid=1, drop=0, stall: buffer <= {pc, rdata}; IF/ID held; pc held; -> HOLD.
- HOLD, stall released: IF/ID <= buffer with valid=1; pc <= pc+4; -> REQ.
- IF/ID update when no redirect:
  - stall: IF/ID holds all fields.
  - no stall, no instruction delivered: if_id_valid <= 0, if_id_instr <= NOP_INSTR (bubble); if_id_pc unchanged.
- Redirect (any state except IDLE, overrides stall):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - IF/ID <= bubble; hold buffer cleared.
  - REQ without gnt -> REQ (new address issued next cycle).
  - REQ with gnt same cycle -> WAIT, drop=1.
  - WAIT without rvalid -> WAIT, drop=1.
  - WAIT with rvalid same cycle -> rdata discarded, -> REQ.
  - HOLD -> REQ.
- Redirect with stall in the same cycle: redirect wins; flushed IF/ID is not held.
- Latency:
  - Request visible the cycle after entering REQ.
  - Instruction appears in IF/ID the edge on which rvalid is sampled.
  - Zero-wait memory (gnt in REQ, rvalid next cycle): one instruction per 2 cycles.
- Exactly one outstanding request; imem_req never asserted in WAIT or HOLD.

Optional Feature:
- Macro IF_STAGE_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt +1 each cycle IF/ID is loaded with valid=1.
  - perf_stall_cnt +1 each cycle stall=1 and redirect_valid=0.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package rv_pkg: XLEN, NOP_INSTR, the if_state_t enum {IDLE, REQ, WAIT, HOLD}, and an if_id_t struct {pc, instr, valid}, reused by the ID/EX register and hazard unit.
- One natural sub-module, if_id_reg: the IF/ID register with hold (stall) and clear (flush) controls. Keep the PC/FSM in if_stage.

Test Plan:
- Reset then release, memory grants immediately, rvalid 1 cycle later -> imem_addr 0x0,0x4,0x8; if_id_pc follows 0x0,0x4,0x8 every 2 cycles, if_id_valid=1.
- Stall asserted while WAIT and rvalid arrives with 0x00500093 at pc 0x8 -> HOLD; IF/ID keeps pc 0x4; on release IF/ID = {0x8, 0x00500093, 1}; next imem_addr 0xC.
- redirect_valid with redirect_pc=0x100 during WAIT; stale rvalid arrives 2 cycles later -> stale data dropped, IF/ID bubble (NOP, valid=0), next imem_addr=0x100.
- Redirect and stall in the same cycle, redirect_pc=0x203 -> IF/ID flushed despite stall; pc=0x200.
- rst asserted mid-WAIT -> next cycle all outputs at reset values; first request at RESET_PC after IDLE.
- With IF_STAGE_PERF_EN: 10 fetches and 3 stall cycles -> perf_fetch_cnt=10, perf_stall_cnt=3.
